data_memory_hs: RTL

- Parametrised successor of the single-port data memory, for the load/store stage.
- Adds a valid/ready request/response handshake, a byte address, and sub-word access sizes: byte, half, word and double.
- Loads are sign- or zero-extended, stores are byte-masked, and misaligned or out-of-range accesses return an error response.
- Every accepted request produces exactly one response, in order; throughput is one request per cycle when the response is consumed.

---
 rtl/data_memory_hs_if.sv | 27 ++
 rtl/data_memory_hs.sv | 119 +++++++++++
 2 files changed

// File: rtl/data_memory_hs_if.sv
// rtl/data_memory_hs_if.sv - request/response handshake bundle for data_memory_hs
interface data_memory_hs_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic [1:0]            ReqSize;
  logic                  ReqSigned;
  logic [DATA_WIDTH-1:0] ReqWData;
  logic                  RspValid;
  logic                  RspReady;
  logic [DATA_WIDTH-1:0] RspData;
  logic                  RspError;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqSize, ReqSigned, ReqWData, RspReady,
    input  ReqReady, RspValid, RspData, RspError
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqSize, ReqSigned, ReqWData, RspReady,
    output ReqReady, RspValid, RspData, RspError
  );
endinterface

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - byte-addressed data memory with valid/ready request/response handshake
// Optional DMEM_CLEAR_ON_RESET_EN: zero the whole array one word per cycle after reset.
module data_memory_hs #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic           Clock,
  input  logic           Reset,
  data_memory_hs_if.slave bus
);
  localparam int B     = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESP  = 2'd1;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [1:0] CLEAR = 2'd2;
  logic [IDX_W-1:0] clr_idx;
`endif

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rsp_valid;
  logic                  rsp_error;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [OFF_W-1:0]      offset;
  logic [OFF_W-1:0]      align_mask;
  logic [3:0]            size_bytes;
  logic                  misaligned, out_of_range, bad_size, req_error;
  logic                  req_ready, accept, store_we;
  logic [6:0]            ext_sh;
  logic [DATA_WIDTH-1:0] word_rd, shifted, aligned, load_val, wr_shifted;
  logic signed [DATA_WIDTH-1:0] aligned_s;
  logic [B-1:0]          byte_en;

  always_comb begin
    word_idx     = bus.ReqAddr >> OFF_W;
    offset       = bus.ReqAddr[OFF_W-1:0];
    size_bytes   = 4'd1 << bus.ReqSize;
    align_mask   = OFF_W'(size_bytes - 4'd1);
    misaligned   = (offset & align_mask) != '0;
    out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
    bad_size     = size_bytes > 4'(B);
    req_error    = misaligned || out_of_range || bad_size;

    // Extension: push the field to the top of the word, then shift back down.
    word_rd   = mem[word_idx[IDX_W-1:0]];
    shifted   = word_rd >> {offset, 3'b000};
    ext_sh    = 7'(DATA_WIDTH) - (7'd8 << bus.ReqSize);
    aligned   = shifted << ext_sh;
    aligned_s = aligned;
    if (bus.ReqSigned)
      load_val = aligned_s >>> ext_sh;
    else
      load_val = aligned >> ext_sh;

    wr_shifted = bus.ReqWData << {offset, 3'b000};
    for (int i = 0; i < B; i++)
      byte_en[i] = (i >= int'(offset)) && (i < int'(offset) + int'(size_bytes));
  end

  assign req_ready = !Reset && (state == IDLE || (state == RESP && bus.RspReady));
  assign accept    = bus.ReqValid && req_ready;
  assign store_we  = accept && bus.ReqWrite && !req_error;

  assign bus.ReqReady = req_ready;
  assign bus.RspValid = rsp_valid;
  assign bus.RspData  = rsp_data;
  assign bus.RspError = rsp_error;

  always_ff @(posedge Clock) begin
    if (Reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      state   <= CLEAR;
      clr_idx <= '0;
`else
      state   <= IDLE;
`endif
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == IDX_W'(DEPTH - 1))
          state <= IDLE;
      end
`endif
      if (accept) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_error <= req_error;
        rsp_data  <= (req_error || bus.ReqWrite) ? '0 : load_val;
      end else if (state == RESP && bus.RspReady) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (!Reset && state == CLEAR)
      mem[clr_idx] <= '0;
    else
`endif
    if (store_we) begin
      for (int i = 0; i < B; i++)
        if (byte_en[i])
          mem[word_idx[IDX_W-1:0]][8*i +: 8] <= wr_shifted[8*i +: 8];
    end
  end
endmodule
